// File: rtl/calendar_counter_if.sv
// Preset/control bus and calendar outputs of calendar_counter.
// The master drives run/quick/load and the preset fields; the slave (the counter) drives time.
interface calendar_counter_if;
    logic        run;
    logic        quick;
    logic        load;
    logic [14:0] year_d;
    logic [3:0]  month_d;
    logic [4:0]  day_d;
    logic [5:0]  hour_d;
    logic [5:0]  min_d;
    logic [5:0]  sec_d;
    logic [2:0]  week_d;

    logic [14:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [4:0]  hour;
    logic [5:0]  minute;
    logic [5:0]  second;
    logic [2:0]  week;
    logic        sec_tick;
    logic        load_err;

    modport master (
        output run, quick, load, year_d, month_d, day_d, hour_d, min_d, sec_d, week_d,
        input  year, month, day, hour, minute, second, week, sec_tick, load_err
    );

    modport slave (
        input  run, quick, load, year_d, month_d, day_d, hour_d, min_d, sec_d, week_d,
        output year, month, day, hour, minute, second, week, sec_tick, load_err
    );
endinterface

// File: rtl/calendar_counter.sv
// Free-running Gregorian calendar clock with preset load and selectable second prescaler.
// All outputs are registered; a load beats a coincident second increment.
module calendar_counter #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned QUICK_DIV = 100_000
) (
    input logic              clk,
    input logic              rst_n,
    calendar_counter_if.slave bus
);
    localparam int unsigned MAX_DIV = (TICK_DIV > QUICK_DIV) ? TICK_DIV : QUICK_DIV;
    localparam int unsigned PW      = $clog2(MAX_DIV + 1);

    logic [PW-1:0] presc_q;
    logic [14:0]   year_q, year_n;
    logic [3:0]    month_q, month_n;
    logic [4:0]    day_q, day_n;
    logic [4:0]    hour_q, hour_n;
    logic [5:0]    min_q, min_n;
    logic [5:0]    sec_q, sec_n;
    logic [2:0]    week_q, week_n;
    logic          sec_tick_q, load_err_q;

    logic [PW-1:0] div_m1;
    logic          wrap;
    logic          load_ok;
    logic [4:0]    dim_cur, dim_load;

    // Divisors are constant, so the modulo checks reduce to fixed logic.
    function automatic logic is_leap(input logic [14:0] y);
        return ((y[1:0] == 2'b00) && ((y % 15'd100) != 15'd0)) || ((y % 15'd400) == 15'd0);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [14:0] y, input logic [3:0] m);
        logic [4:0] d;
        case (m)
            4'd2:                      d = is_leap(y) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   d = 5'd30;
            default:                   d = 5'd31;
        endcase
        return d;
    endfunction

    assign div_m1   = bus.quick ? PW'(QUICK_DIV - 1) : PW'(TICK_DIV - 1);
    assign wrap     = bus.run && (presc_q >= div_m1);
    assign dim_cur  = days_in_month(year_q, month_q);
    assign dim_load = days_in_month(bus.year_d, bus.month_d);

    assign load_ok = (bus.year_d <= 15'd9999) &&
                     (bus.month_d >= 4'd1) && (bus.month_d <= 4'd12) &&
                     (bus.day_d >= 5'd1) && (bus.day_d <= dim_load) &&
                     (bus.hour_d < 6'd24) && (bus.min_d < 6'd60) && (bus.sec_d < 6'd60) &&
                     (bus.week_d != 3'd7);

    // One-second carry cascade from second through year.
    always_comb begin
        sec_n   = sec_q + 6'd1;
        min_n   = min_q;
        hour_n  = hour_q;
        day_n   = day_q;
        month_n = month_q;
        year_n  = year_q;
        week_n  = week_q;
        if (sec_q == 6'd59) begin
            sec_n = 6'd0;
            min_n = min_q + 6'd1;
            if (min_q == 6'd59) begin
                min_n  = 6'd0;
                hour_n = hour_q + 5'd1;
                if (hour_q == 5'd23) begin
                    hour_n = 5'd0;
                    week_n = (week_q == 3'd6) ? 3'd0 : week_q + 3'd1;
                    day_n  = day_q + 5'd1;
                    if (day_q >= dim_cur) begin
                        day_n   = 5'd1;
                        month_n = month_q + 4'd1;
                        if (month_q >= 4'd12) begin
                            month_n = 4'd1;
                            year_n  = (year_q >= 15'd9999) ? 15'd0 : year_q + 15'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            year_q     <= 15'd2000;
            month_q    <= 4'd1;
            day_q      <= 5'd1;
            hour_q     <= 5'd0;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
            week_q     <= 3'd6;
            sec_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            sec_tick_q <= 1'b0;
            load_err_q <= 1'b0;
            if (bus.load && load_ok) begin
                presc_q <= '0;
                year_q  <= bus.year_d;
                month_q <= bus.month_d;
                day_q   <= bus.day_d;
                hour_q  <= bus.hour_d[4:0];
                min_q   <= bus.min_d;
                sec_q   <= bus.sec_d;
                week_q  <= bus.week_d;
            end else begin
                load_err_q <= bus.load;
                if (wrap) begin
                    presc_q    <= '0;
                    sec_tick_q <= 1'b1;
                    year_q     <= year_n;
                    month_q    <= month_n;
                    day_q      <= day_n;
                    hour_q     <= hour_n;
                    min_q      <= min_n;
                    sec_q      <= sec_n;
                    week_q     <= week_n;
                end else if (bus.run) begin
                    presc_q <= presc_q + 1'b1;
                end
            end
        end
    end

    assign bus.year     = year_q;
    assign bus.month    = month_q;
    assign bus.day      = day_q;
    assign bus.hour     = hour_q;
    assign bus.minute   = min_q;
    assign bus.second   = sec_q;
    assign bus.week     = week_q;
    assign bus.sec_tick = sec_tick_q;
    assign bus.load_err = load_err_q;
endmodule
